vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_axis_fsm.sv | 81 ++++++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Purpose: shared timing defaults, axis state encoding and total-width helper for the VGA generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  // 640x480 @ 60 Hz timing, in pixel clocks (horizontal) and lines (vertical).
  localparam int H_VID_DEF = 640;
  localparam int H_FP_DEF  = 16;
  localparam int H_SW_DEF  = 96;
  localparam int H_BP_DEF  = 48;
  localparam int V_VID_DEF = 480;
  localparam int V_FP_DEF  = 10;
  localparam int V_SW_DEF  = 2;
  localparam int V_BP_DEF  = 33;

  // Both axis counters are 10 bits wide, so an axis may be at most 1024 long.
  localparam int CNT_W       = 10;
  localparam int CNT_MAX_TOT = 1 << CNT_W;

  // Segments of one axis, in scan order.
  typedef enum logic [1:0] {
    AX_VIS  = 2'd0,
    AX_FP   = 2'd1,
    AX_SYNC = 2'd2,
    AX_BP   = 2'd3
  } axis_state_t;

  function automatic int axis_total(input int vid, input int fp, input int sw, input int bp);
    return vid + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// Purpose: one scan axis (horizontal or vertical): position counter plus segment FSM.
// Latency: count/state update on the clock edge where step is high; wrap and state_nxt are same-cycle look-ahead.
// Backpressure: none; the axis advances whenever step is high.
//
// Ports:
//   clk, n_rst  - clock and synchronous active-low reset (count -> 0, state -> AX_VIS)
//   step        - advance by one position on this edge
//   count       - current position, 0 .. total-1
//   state       - segment holding the current position
//   state_nxt   - segment the axis will be in after this edge (lets the parent register
//                 status flags in lock-step with count)
//   wrap        - this edge takes count from total-1 back to 0
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int SEG_VID = H_VID_DEF,
  parameter int SEG_FP  = H_FP_DEF,
  parameter int SEG_SW  = H_SW_DEF,
  parameter int SEG_BP  = H_BP_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              step,
  output logic [CNT_W-1:0]  count,
  output axis_state_t       state,
  output axis_state_t       state_nxt,
  output logic              wrap
);

  localparam int TOT = axis_total(SEG_VID, SEG_FP, SEG_SW, SEG_BP);

  // Segment boundaries at counter width; the FSM moves when the next count hits one.
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(SEG_VID);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(SEG_VID + SEG_FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(SEG_VID + SEG_FP + SEG_SW);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOT - 1);

  // A zero-width segment would make its start boundary coincide with the next one and
  // the FSM would skip past it and stall, so every segment must be at least one long.
  if (TOT > CNT_MAX_TOT) begin : g_tot_too_big
    $error("vga_axis_fsm: axis total %0d does not fit a %0d-bit counter", TOT, CNT_W);
  end
  if (SEG_VID < 1 || SEG_FP < 1 || SEG_SW < 1 || SEG_BP < 1) begin : g_empty_segment
    $error("vga_axis_fsm: every segment width must be at least 1");
  end

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    state_nxt = state;
    if (step) begin
      if (count == LAST) begin
        count_nxt = '0;
        wrap      = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end

      case (state)
        AX_VIS:  if (count_nxt == FP_START)   state_nxt = AX_FP;
        AX_FP:   if (count_nxt == SYNC_START) state_nxt = AX_SYNC;
        AX_SYNC: if (count_nxt == BP_START)   state_nxt = AX_BP;
        AX_BP:   if (wrap)                    state_nxt = AX_VIS;
        default:                              state_nxt = AX_VIS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
      state <= AX_VIS;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing: pixel/line counters, active-low syncs, visible-area and frame-start flags.
// Latency: every output is a register; status flags are decoded from the next count so they line up with it.
// Backpressure: none; free-running at one pixel per clk_25 edge.
//
// Ports:
//   clk_25          - pixel clock
//   n_rst           - synchronous active-low reset
//   horizontal_num  - pixel column, 0 .. HTOT-1
//   vertical_num    - line, 0 .. VTOT-1
//   hsync, vsync    - active-low sync pulses
//   load_enable     - current pixel is in the visible area
//   frame_start     - one-cycle pulse while at pixel (0,0), not during reset
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HVID = H_VID_DEF,
  parameter int HFP  = H_FP_DEF,
  parameter int HSW  = H_SW_DEF,
  parameter int HBP  = H_BP_DEF,
  parameter int VVID = V_VID_DEF,
  parameter int VFP  = V_FP_DEF,
  parameter int VSW  = V_SW_DEF,
  parameter int VBP  = V_BP_DEF
) (
  input  logic       clk_25,
  input  logic       n_rst,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       hsync,
  output logic       vsync,
  output logic       load_enable,
  output logic       frame_start
);

  localparam int HTOT = axis_total(HVID, HFP, HSW, HBP);
  localparam int VTOT = axis_total(VVID, VFP, VSW, VBP);

  if (HTOT > CNT_MAX_TOT || VTOT > CNT_MAX_TOT) begin : g_raster_too_big
    $error("vga_timing_gen: HTOT=%0d / VTOT=%0d exceed the 10-bit counters", HTOT, VTOT);
  end

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  axis_state_t      h_state;
  axis_state_t      h_state_nxt;
  axis_state_t      v_state;
  axis_state_t      v_state_nxt;
  logic             h_wrap;
  logic             v_wrap;

  // Horizontal axis moves every pixel clock.
  vga_axis_fsm #(
    .SEG_VID (HVID),
    .SEG_FP  (HFP),
    .SEG_SW  (HSW),
    .SEG_BP  (HBP)
  ) u_h_axis (
    .clk       (clk_25),
    .n_rst     (n_rst),
    .step      (1'b1),
    .count     (h_count),
    .state     (h_state),
    .state_nxt (h_state_nxt),
    .wrap      (h_wrap)
  );

  // Vertical axis moves on the same edge the horizontal counter wraps, so line and
  // column change together and are never a cycle apart.
  vga_axis_fsm #(
    .SEG_VID (VVID),
    .SEG_FP  (VFP),
    .SEG_SW  (VSW),
    .SEG_BP  (VBP)
  ) u_v_axis (
    .clk       (clk_25),
    .n_rst     (n_rst),
    .step      (h_wrap),
    .count     (v_count),
    .state     (v_state),
    .state_nxt (v_state_nxt),
    .wrap      (v_wrap)
  );

  assign horizontal_num = h_count;
  assign vertical_num   = v_count;

  // Flags are registered from the look-ahead states rather than decoded from the
  // current ones; the current states are only kept for observability.
  logic unused_states;
  assign unused_states = ^{h_state, v_state};

  // Reset clears load_enable even though both axes sit in their visible segment, so
  // pixel (0,0) straight after reset is blanked; the first released edge lands on (1,0).
  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      load_enable <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_state_nxt != AX_SYNC);
      vsync       <= (v_state_nxt != AX_SYNC);
      load_enable <= (h_state_nxt == AX_VIS) && (v_state_nxt == AX_VIS);
      // Both axes wrapping on this edge means the next position is (0,0).
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule
